// File: rtl/peak_pkg.sv
// rtl/peak_pkg.sv - shared widths, event record and tracker states for peak handling
// Purpose: types and constants shared by peak_detection and its consumers.
// Contents:
//   DATA_WIDTH   signed Q8.8 peak value width
//   IDX_WIDTH    sample index width
//   peak_event_t value/index/gap record stored per queued event
//   ref_state_t  refractory tracker state
//   sat_inc8     saturating 8-bit increment used by the event counters
package peak_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int IDX_WIDTH  = 14;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] value;
    logic [IDX_WIDTH-1:0]         index;
    logic [IDX_WIDTH-1:0]         gap;
  } peak_event_t;

  typedef enum logic {
    NO_REF   = 1'b0,
    HAVE_REF = 1'b1
  } ref_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO
// Purpose: circular buffer whose head is read combinationally from storage.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous flush (priority over push/pop)
//   push, din     write request and data; accepted when not full or when popping
//   pop, dout     read request and head data (valid while !empty)
//   full, empty   occupancy flags
//   level         registered entry count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; entries are only observed below level.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/peak_event_buffer.sv
// rtl/peak_event_buffer.sv - refractory filter and event queue for detected peaks
// Purpose: captures peak_point pulses, rejects peaks inside the refractory gap,
//   tags accepted peaks with distance to the previous accepted peak and queues them.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   clear                          synchronous flush of queue, counters, tracker
//   min_gap                        refractory distance in samples (0 disables)
//   peak_point, peakx, peaky       peak pulse with value and sample index
//   ev_valid, ev_ready             head handshake
//   ev_value, ev_index, ev_gap     head event fields
//   level                          entries held
//   overflow, drop_count           loss to full queue (sticky / saturating)
//   reject_count                   refractory rejections (saturating)
module peak_event_buffer
  import peak_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [IDX_WIDTH-1:0]  min_gap,
  input  logic                  peak_point,
  input  logic [DATA_WIDTH-1:0] peakx,
  input  logic [IDX_WIDTH-1:0]  peaky,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [DATA_WIDTH-1:0] ev_value,
  output logic [IDX_WIDTH-1:0]  ev_index,
  output logic [IDX_WIDTH-1:0]  ev_gap,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  output logic [7:0]            reject_count
);

  ref_state_t           state;
  logic [IDX_WIDTH-1:0] last_idx;
  logic [IDX_WIDTH-1:0] gap_d;
  logic                 reject;
  logic                 accept;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 dropped;
  peak_event_t          wr_evt;
  peak_event_t          head;

  // Modular subtraction keeps the distance correct across index rollover.
  assign gap_d   = peaky - last_idx;
  assign reject  = peak_point && (state == HAVE_REF) && (gap_d < min_gap);
  assign accept  = peak_point && !reject;
  assign pop     = ev_valid && ev_ready;
  assign dropped = accept && full && !pop;

  assign wr_evt.value = peakx;
  assign wr_evt.index = peaky;
  assign wr_evt.gap   = (state == HAVE_REF) ? gap_d : '0;

  sync_fifo #(
    .WIDTH($bits(peak_event_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (accept),
    .din   (wr_evt),
    .pop   (ev_ready),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign ev_valid = !empty;
  assign ev_value = head.value;
  assign ev_index = head.index;
  assign ev_gap   = head.gap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= NO_REF;
      last_idx     <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      reject_count <= '0;
    end else if (clear) begin
      state        <= NO_REF;
      last_idx     <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      reject_count <= '0;
    end else begin
      // The refractory window advances even when the queue write is lost.
      if (accept) begin
        state    <= HAVE_REF;
        last_idx <= peaky;
      end
      if (reject) reject_count <= sat_inc8(reject_count);
      if (dropped) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc8(drop_count);
      end
    end
  end

endmodule

// File: tb/tb_peak_event_buffer.sv
// tb/tb_peak_event_buffer.sv - scoreboard bench for peak_event_buffer
module tb_peak_event_buffer;
  import peak_pkg::*;

  localparam int DEPTH = 16;
  localparam int IW    = IDX_WIDTH;
  localparam int MODI  = 1 << IW;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct {
    int value;
    int index;
    int gap;
  } ev_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  clear = 1'b0;
  logic [IW-1:0]         min_gap = '0;
  logic                  peak_point = 1'b0;
  logic [DATA_WIDTH-1:0] peakx = '0;
  logic [IW-1:0]         peaky = '0;
  logic                  ev_valid;
  logic                  ev_ready = 1'b0;
  logic [DATA_WIDTH-1:0] ev_value;
  logic [IW-1:0]         ev_index;
  logic [IW-1:0]         ev_gap;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic [7:0]            drop_count;
  logic [7:0]            reject_count;

  peak_event_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .min_gap      (min_gap),
    .peak_point   (peak_point),
    .peakx        (peakx),
    .peaky        (peaky),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_value     (ev_value),
    .ev_index     (ev_index),
    .ev_gap       (ev_gap),
    .level        (level),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .reject_count (reject_count)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  have_ref = 0;
  int  last = 0;
  int  m_ovf = 0, m_drop = 0, m_rej = 0;
  int  lvl_now = 0, ovf_now = 0, drop_now = 0, rej_now = 0;
  bit  mon_on = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the model predicts what the coming edge commits.
  task automatic step(input bit pk, input int y, input int x, input bit rdy,
                      input bit clr, input int mg);
    int  d;
    bit  pop;
    ev_t e;
    @(posedge clk);
    #1;
    peak_point = pk;
    peaky      = IW'(y);
    peakx      = DATA_WIDTH'(x);
    ev_ready   = rdy;
    clear      = clr;
    min_gap    = IW'(mg);
    lvl_now  = exp_q.size();
    ovf_now  = m_ovf;
    drop_now = m_drop;
    rej_now  = m_rej;
    mon_on   = 1;
    if (clr) begin
      exp_q.delete();
      have_ref = 0;
      m_ovf = 0; m_drop = 0; m_rej = 0;
    end else if (pk) begin
      d   = (y - last + MODI) % MODI;
      pop = (lvl_now > 0) && rdy;
      if (have_ref && d < mg) begin
        m_rej = (m_rej < 255) ? m_rej + 1 : 255;
      end else begin
        e.value = x & 16'hFFFF;
        e.index = y;
        e.gap   = have_ref ? d : 0;
        last = y;
        have_ref = 1;
        if (lvl_now < DEPTH || pop) exp_q.push_back(e);
        else begin
          m_ovf = 1;
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
      end
    end
  endtask

  task automatic idle(input bit rdy, input int mg);
    step(0, 0, 0, rdy, 0, mg);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_on) begin
      chk("level", int'(level), lvl_now);
      chk("ev_valid", int'(ev_valid), int'(lvl_now != 0));
      chk("overflow", int'(overflow), ovf_now);
      chk("drop_count", int'(drop_count), drop_now);
      chk("reject_count", int'(reject_count), rej_now);
      if (ev_valid && ev_ready && !clear) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_value", int'(ev_value), e.value);
          chk("ev_index", int'(ev_index), e.index);
          chk("ev_gap", int'(ev_gap), e.gap);
        end
      end
    end
  end

  task automatic drain(input int mg);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1, mg);
    idle(1, mg);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int cur;
    int mg;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ev_valid", int'(ev_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_reject", int'(reject_count), 0);
    rst = 1'b0;

    // Basic spacing: gaps 0, 10, 15.
    step(0, 0, 0, 1, 1, 4);
    step(1, 10, 16'h0200, 1, 0, 4); idle(1, 4);
    step(1, 20, 16'h0180, 1, 0, 4); idle(1, 4);
    step(1, 35, 16'h0300, 1, 0, 4);
    drain(4);
    chk("t1_reject", int'(reject_count), 0);

    // Refractory rejection; 110 measured from 100.
    step(0, 0, 0, 1, 1, 8);
    step(1, 100, 16'h0111, 1, 0, 8);
    step(1, 103, 16'h0222, 1, 0, 8);
    step(1, 110, 16'h0333, 1, 0, 8);
    drain(8);
    chk("t2_reject", int'(reject_count), 1);

    // Index rollover.
    step(0, 0, 0, 1, 1, 4);
    step(1, 16382, 16'hFF00, 1, 0, 4); idle(1, 4);
    step(1, 2, 16'h0080, 1, 0, 4);
    drain(4);
    chk("t3_reject", int'(reject_count), 0);

    // Fill past capacity, then push while full with a pop.
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 18; i++) step(1, 200 + i, i * 37, 0, 0, 0);
    idle(0, 0);
    chk("t4_level", int'(level), 16);
    chk("t4_overflow", int'(overflow), 1);
    chk("t4_drop", int'(drop_count), 2);
    step(1, 300, 16'h1234, 1, 0, 0);
    idle(0, 0);
    chk("t5_level", int'(level), 16);
    chk("t5_drop", int'(drop_count), 2);
    drain(0);

    // clear beats a coincident peak.
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 400 + i * 5, i, 0, 0, 0);
    idle(0, 0);
    step(1, 420, 7, 0, 1, 0);
    idle(0, 0);
    chk("t6_level", int'(level), 0);
    chk("t6_valid", int'(ev_valid), 0);
    chk("t6_overflow", int'(overflow), 0);
    step(1, 500, 16'h0042, 1, 0, 0);
    drain(0);

    // Randomized traffic.
    cur = 16300;
    mg  = 5;
    for (int i = 0; i < 2500; i++) begin
      if (i % 250 == 0) mg = $urandom_range(0, 12);
      cur = (cur + $urandom_range(0, 10)) % MODI;
      step(($urandom_range(0, 2) == 0), cur, $urandom_range(0, 65535),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 150) == 0), mg);
    end
    drain(mg);

    mon_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
